// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, FSM state type and the combinational round functions
// used by the compression core and its message schedule.
package sha256_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] H_INIT = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                     input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: 16-word sliding window, loaded with the block and
// advanced once per round; w[0] is the current Wt.
module sha256_msg_sched
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         adv_i,
  input  logic [511:0] block_i,
  output logic [31:0]  wt_o
);

  logic [0:15][31:0] w_q, w_d;
  logic [31:0]       w_new;

  always_comb begin
    w_new = small_sigma1(w_q[14]) + w_q[9] + small_sigma0(w_q[1]) + w_q[0];
    w_d   = w_q;
    if (load_i) begin
      w_d = block_i;
    end else if (adv_i) begin
      w_d = {w_q[1:15], w_new};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q <= '0;
    end else begin
      w_q <= w_d;
    end
  end

  assign wt_o = w_q[0];

endmodule

// File: rtl/sha256_compress_core.sv
// Iterative SHA-256 compression: one round per clock, ROUNDS rounds per block,
// valid/ready handshakes on both the block input and the digest output.
module sha256_compress_core
  import sha256_pkg::*;
#(
  parameter int unsigned ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] block_in,
  input  logic [255:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] digest_out
);

  localparam logic [5:0] T_LAST = 6'(ROUNDS - 1);

  state_e           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [255:0]     digest_q;
  logic [0:7][31:0] hreg_q;
  logic [0:7][31:0] wk_q, wk_d;
  logic [0:7][31:0] digest_d;
  logic [5:0]       t_q;

  logic [31:0] wt, t1, t2;
  logic        accept;
  logic        advance;

  assign accept  = (state_q == IDLE) && in_valid && in_ready_q;
  assign advance = (state_q == ROUND);

  sha256_msg_sched u_msg_sched (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (accept),
    .adv_i   (advance),
    .block_i (block_in),
    .wt_o    (wt)
  );

  // Index 0..7 of the working set is a..h.
  always_comb begin
    t1 = wk_q[7] + big_sigma1(wk_q[4]) + ch(wk_q[4], wk_q[5], wk_q[6]) + K[t_q] + wt;
    t2 = big_sigma0(wk_q[0]) + maj(wk_q[0], wk_q[1], wk_q[2]);
    wk_d[0] = t1 + t2;
    wk_d[1] = wk_q[0];
    wk_d[2] = wk_q[1];
    wk_d[3] = wk_q[2];
    wk_d[4] = wk_q[3] + t1;
    wk_d[5] = wk_q[4];
    wk_d[6] = wk_q[5];
    wk_d[7] = wk_q[6];
    for (int unsigned i = 0; i < 8; i++) begin
      digest_d[i] = hreg_q[i] + wk_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      digest_q    <= '0;
      hreg_q      <= '0;
      wk_q        <= '0;
      t_q         <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            hreg_q     <= state_in;
            wk_q       <= state_in;
            t_q        <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ROUND;
          end
        end
        ROUND: begin
          wk_q <= wk_d;
          if (t_q == T_LAST) begin
            state_q <= FINAL;
          end else begin
            t_q <= t_q + 6'd1;
          end
        end
        FINAL: begin
          digest_q    <= digest_d;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign digest_out = digest_q;

endmodule
